// File: rtl/fu_result_buffer.sv
// fu_result_buffer: CDB transmit buffer for one functional unit.
// Completed results {value, tag, mis_predict, target_pc} queue in a small FIFO.
// The oldest entry is offered to the CDB arbiter. It retires only in the cycle
// the arbiter selects this FU, so results that lose arbitration are kept.
// Optional macro FU_RESULT_BYPASS_EN: when the buffer is empty, an incoming
// result is presented combinationally. If it is granted in that same cycle it
// is never written, which gives zero-cycle latency.
module fu_result_buffer #(
    parameter int DEPTH       = 4,
    parameter int FU_ID       = 0,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         in_valid,
    input  logic [XLEN-1:0]              in_value,
    input  logic [ROB_TAG_LEN-1:0]       in_tag,
    input  logic                         in_mis_predict,
    input  logic [XLEN-1:0]              in_target_pc,
    output logic                         in_ready,
    input  logic                         cdb_enable,
    input  logic [1:0]                   cdb_select,
    output logic                         out_ready,
    output logic [XLEN-1:0]              out_value,
    output logic [ROB_TAG_LEN-1:0]       out_tag,
    output logic                         out_mis_predict,
    output logic [XLEN-1:0]              out_target_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]        value_mem_q [DEPTH];
    logic [ROB_TAG_LEN-1:0] tag_mem_q   [DEPTH];
    logic                   mp_mem_q    [DEPTH];
    logic [XLEN-1:0]        pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic stored_valid;
    logic push;
    logic grant;
    logic wr_en;
    logic rd_en;

    // in_ready comes only from the registered count, so the arbiter's select
    // never feeds back into the FU's stall signal.
    assign stored_valid = (count_q != '0);
    assign in_ready     = (count_q != FULL_COUNT);
    assign push         = in_valid && in_ready;
    assign count        = count_q;

`ifdef FU_RESULT_BYPASS_EN
    logic bypass;
    assign bypass = !stored_valid && in_valid && !squash;
`endif

    // Present the head entry; zeros when empty (or the live input in bypass mode).
    always_comb begin
        out_ready       = 1'b0;
        out_value       = '0;
        out_tag         = '0;
        out_mis_predict = 1'b0;
        out_target_pc   = '0;
        if (stored_valid) begin
            out_ready       = 1'b1;
            out_value       = value_mem_q[head_q];
            out_tag         = tag_mem_q[head_q];
            out_mis_predict = mp_mem_q[head_q];
            out_target_pc   = pc_mem_q[head_q];
        end
`ifdef FU_RESULT_BYPASS_EN
        else if (bypass) begin
            out_ready       = 1'b1;
            out_value       = in_value;
            out_tag         = in_tag;
            out_mis_predict = in_mis_predict;
            out_target_pc   = in_target_pc;
        end
`endif
    end

    assign grant = cdb_enable && (cdb_select == 2'(FU_ID)) && out_ready;

`ifdef FU_RESULT_BYPASS_EN
    // A bypassed result that is granted immediately never touches storage.
    assign wr_en = push && !(bypass && grant);
`else
    assign wr_en = push;
`endif
    assign rd_en = grant && stored_valid;

    // Next pointers and occupancy; squash empties the buffer and drops any
    // same-cycle push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) tail_d = tail_q + PTR_W'(1);
            if (rd_en) head_d = head_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while count covers them.
    always_ff @(posedge clock) begin
        if (wr_en && !squash && !reset) begin
            value_mem_q[tail_q] <= in_value;
            tag_mem_q[tail_q]   <= in_tag;
            mp_mem_q[tail_q]    <= in_mis_predict;
            pc_mem_q[tail_q]    <= in_target_pc;
        end
    end

endmodule
